// File: rtl/aes_inv_cipher_iter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aes_inv_cipher_iter
// Iterative AES inverse cipher (InvCipher). One round is applied per accepted
// round key. Round keys are requested in descending order w[NR] .. w[0]
// through a request/valid handshake. The plaintext is returned through a
// valid/ready handshake.
//
// Ports
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous, active-high reset
//   start       in   1        begin a decryption (sampled only when idle)
//   ciphertext  in   128      input block, captured on the accepted start cycle
//   key_req     out  1        waiting for the round key at key_idx
//   key_idx     out  KIDX_W   requested round-key index, NR down to 0
//   round_key   in   128      round key w[key_idx]
//   key_valid   in   1        round_key valid; consumed when key_req is high
//   busy        out  1        block in flight (start accepted .. output taken)
//   out_valid   out  1        plaintext valid and held
//   out_ready   in   1        consumer takes plaintext when out_valid is high
//   plaintext   out  128      decrypted block
//
// Byte (row r, column c) of a 128-bit state sits at bits [127-8*(4c+r) -: 8].
// -----------------------------------------------------------------------------
module aes_inv_cipher_iter #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [127:0]      ciphertext,
    output logic              key_req,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      round_key,
    input  logic              key_valid,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      plaintext
);

    localparam logic [KIDX_W-1:0] KIDX_NR  = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] KIDX_NR1 = KIDX_W'(NR - 1);
    localparam logic [KIDX_W-1:0] KIDX_ONE = KIDX_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } state_e;

    // ------------------------------------------------------------------
    // Round functions
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // out[r][c] = in[r][(c-r) mod 4]: row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    // One column through the {0e,0b,0d,09} circulant. The multiples are
    // built from a single xtime chain per byte: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [3:0][7:0] a, m9, mb, md, me;
        logic [7:0]      x2, x4, x8;
        logic [31:0]     r;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        r = '0;
        for (int row = 0; row < 4; row++) begin
            r[31-8*row -: 8] = me[row] ^ mb[(row+1)%4] ^ md[(row+2)%4] ^ m9[(row+3)%4];
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [127:0]        st_q, st_d;
    logic [127:0]        pt_q, pt_d;
    logic [KIDX_W-1:0]   key_idx_q, key_idx_d;
    logic                key_req_q, key_req_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;

    // ------------------------------------------------------------------
    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
    // ------------------------------------------------------------------
    logic [127:0] isr, isb, ark, imc;
    logic         key_acc;

    assign isr = inv_shift_rows(st_q);

    aes_inv_sbox128 u_inv_sbox (
        .din  (isr),
        .dout (isb)
    );

    // The final round reuses ark directly; middle rounds take it through
    // InvMixColumns.
    assign ark     = isb ^ round_key;
    assign imc     = inv_mix_columns(ark);
    assign key_acc = key_req_q & key_valid;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        pt_d        = pt_q;
        key_idx_d   = key_idx_q;
        key_req_d   = key_req_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    st_d      = ciphertext;
                    key_idx_d = KIDX_NR;
                    busy_d    = 1'b1;
                    key_req_d = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (key_acc) begin
                    st_d      = st_q ^ round_key;
                    key_idx_d = KIDX_NR1;
                    state_d   = ROUND;
                end
            end
            ROUND: begin
                if (key_acc) begin
                    st_d      = imc;
                    key_idx_d = key_idx_q - KIDX_ONE;
                    if (key_idx_q == KIDX_ONE) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                // key_idx is already 0 here and stays there.
                if (key_acc) begin
                    pt_d        = ark;
                    key_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here, so a start held
                // across the handshake is taken one cycle later in IDLE.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            pt_q        <= '0;
            key_idx_q   <= '0;
            key_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            pt_q        <= pt_d;
            key_idx_q   <= key_idx_d;
            key_req_q   <= key_req_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign key_req   = key_req_q;
    assign key_idx   = key_idx_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign plaintext = pt_q;

endmodule

// -----------------------------------------------------------------------------
// aes_inv_sbox128
// Combinational inverse S-box applied to all 16 bytes of a block.
// Each byte goes through the inverse affine map and then the multiplicative
// inverse in GF(2^8) mod 0x11b, computed as a^254 (0 maps to 0).
//
// Ports
//   din   in   128  input block
//   dout  out  128  InvSubBytes(din)
// -----------------------------------------------------------------------------
module aes_inv_sbox128 (
    input  logic [127:0] din,
    output logic [127:0] dout
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add product in GF(2^8).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse of the forward affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    for (genvar g = 0; g < 16; g++) begin : g_byte
        assign dout[8*g +: 8] = gf_inv(inv_affine(din[8*g +: 8]));
    end

endmodule
